// File: rtl/frame_block_sched.sv
`default_nettype none
// ============================================================================
//  Module   : frame_block_sched
//  Purpose  : Frame-buffer block scheduler for the camera->SDRAM->HDMI path.
//             Tracks which block the camera writer fills (W), which block
//             holds the latest completed frame (R), which block the display
//             reader is scanning (D) and which block is locked for a
//             screenshot (S). A block is never handed to the writer while
//             the reader or the screenshot engine holds it.
//  Revision : 1.0  initial release
// ============================================================================
module frame_block_sched #(
    parameter int NUM_BLOCKS = 4,
    parameter int BLK_W      = 2,
    parameter int DROP_W     = 16
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    input  logic              shot_req,
    input  logic              shot_done,
    output logic [BLK_W-1:0]  occupy_block_num_write,
    output logic [BLK_W-1:0]  disp_block_num,
    output logic [BLK_W-1:0]  rd_block_num,
    output logic [BLK_W-1:0]  occupy_block_num_screenshot,
    output logic              disp_valid,
    output logic              shot_active,
    output logic              shot_ack,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] c_DROP_MAX = {DROP_W{1'b1}};

    // Block ownership state
    logic [BLK_W-1:0]  r_w;
    logic [BLK_W-1:0]  r_r;
    logic [BLK_W-1:0]  r_d;
    logic [BLK_W-1:0]  r_s;
    logic              r_disp_valid;
    logic              r_rd_valid;
    logic              r_shot_active;
    logic              r_shot_ack;
    logic              r_taken;      // current R already latched by the reader
    logic [DROP_W-1:0] r_drop_cnt;

    // Next-state view of reader / screenshot ownership, used to build the
    // exclusion set for the next write block.
    logic              w_rd_take;
    logic [BLK_W-1:0]  w_d_next;
    logic              w_rd_valid_next;
    logic              w_shot_accept;
    logic              w_shot_release;
    logic [BLK_W-1:0]  w_s_next;
    logic              w_shot_active_next;
    logic              w_drop;
    logic [BLK_W-1:0]  w_free_blk;

    // Reader latches the latest completed frame only when one exists
    assign w_rd_take       = rd_frame_start && r_disp_valid;
    assign w_d_next        = w_rd_take ? r_r : r_d;
    assign w_rd_valid_next = r_rd_valid || w_rd_take;

    // A release in the same cycle as a request wins: the request is dropped
    assign w_shot_accept      = shot_req && r_disp_valid && !r_shot_active && !shot_done;
    assign w_shot_release     = shot_done && r_shot_active;
    assign w_s_next           = w_shot_accept ? r_r : r_s;
    assign w_shot_active_next = w_shot_accept ? 1'b1 :
                                (w_shot_release ? 1'b0 : r_shot_active);

    // A completed frame is dropped if it is replaced before the reader took it;
    // a reader start in the same cycle still counts as having taken it.
    assign w_drop = wr_frame_done && r_disp_valid && !r_taken && !rd_frame_start;

    // Pick the lowest-index block outside {W_old, D_new, S_new}. Scanning from
    // the top down lets the last match (the lowest index) win.
    always_comb begin
        w_free_blk = r_w;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (!((r_w == BLK_W'(i)) ||
                  (w_rd_valid_next && (w_d_next == BLK_W'(i))) ||
                  (w_shot_active_next && (w_s_next == BLK_W'(i))))) begin
                w_free_blk = BLK_W'(i);
            end
        end
    end

    // Ownership, flag and counter registers
    always_ff @(posedge clk) begin
        if (rest) begin
            r_w           <= '0;
            r_r           <= '0;
            r_d           <= '0;
            r_s           <= '0;
            r_disp_valid  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_shot_active <= 1'b0;
            r_shot_ack    <= 1'b0;
            r_taken       <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_d           <= w_d_next;
            r_rd_valid    <= w_rd_valid_next;
            r_s           <= w_s_next;
            r_shot_active <= w_shot_active_next;
            r_shot_ack    <= w_shot_accept;

            if (wr_frame_done) begin
                r_r          <= r_w;
                r_w          <= w_free_blk;
                r_disp_valid <= 1'b1;
                r_taken      <= 1'b0;
            end else if (w_rd_take) begin
                r_taken      <= 1'b1;
            end

            if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    // Writer must never share a block with the reader or the screenshot lock
    always_ff @(posedge clk) begin
        if (!rest) begin
            assert (!(r_rd_valid && (r_w == r_d)));
            assert (!(r_shot_active && (r_w == r_s)));
        end
    end

    assign occupy_block_num_write      = r_w;
    assign disp_block_num              = r_r;
    assign rd_block_num                = r_d;
    assign occupy_block_num_screenshot = r_s;
    assign disp_valid                  = r_disp_valid;
    assign shot_active                 = r_shot_active;
    assign shot_ack                    = r_shot_ack;
    assign drop_cnt                    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_block_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_block_sched
//  Purpose  : Self-checking bench for frame_block_sched: directed scenarios
//             followed by a long randomized event run, all compared against
//             a behavioural block-ownership model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_block_sched;

    localparam int c_NB     = 4;
    localparam int c_BLK_W  = 2;
    localparam int c_DROP_W = 16;
    localparam int c_DROP_MAX = (1 << c_DROP_W) - 1;

    logic                clk = 1'b0;
    logic                rest = 1'b1;
    logic                wr_frame_done = 1'b0;
    logic                rd_frame_start = 1'b0;
    logic                shot_req = 1'b0;
    logic                shot_done = 1'b0;
    logic [c_BLK_W-1:0]  w_blk;
    logic [c_BLK_W-1:0]  r_blk;
    logic [c_BLK_W-1:0]  d_blk;
    logic [c_BLK_W-1:0]  s_blk;
    logic                dv;
    logic                sa;
    logic                ack;
    logic [c_DROP_W-1:0] drops;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_w, m_r, m_d, m_s, m_drop;
    bit m_dv, m_rv, m_sa, m_ack, m_taken;

    frame_block_sched #(
        .NUM_BLOCKS (c_NB),
        .BLK_W      (c_BLK_W),
        .DROP_W     (c_DROP_W)
    ) dut (
        .clk                         (clk),
        .rest                        (rest),
        .wr_frame_done               (wr_frame_done),
        .rd_frame_start              (rd_frame_start),
        .shot_req                    (shot_req),
        .shot_done                   (shot_done),
        .occupy_block_num_write      (w_blk),
        .disp_block_num              (r_blk),
        .rd_block_num                (d_blk),
        .occupy_block_num_screenshot (s_blk),
        .disp_valid                  (dv),
        .shot_active                 (sa),
        .shot_ack                    (ack),
        .drop_cnt                    (drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural rules: every event is judged on the state before the edge.
    task automatic model_step(input bit rs, input bit wd, input bit rf,
                              input bit sq, input bit sd);
        int  nd, ns, nw;
        bit  nrv, nsa, take, acc, found;
        if (rs) begin
            m_w = 0; m_r = 0; m_d = 0; m_s = 0; m_drop = 0;
            m_dv = 0; m_rv = 0; m_sa = 0; m_ack = 0; m_taken = 0;
            return;
        end
        take = rf && m_dv;
        nd   = take ? m_r : m_d;
        nrv  = m_rv || take;
        acc  = sq && m_dv && !m_sa && !sd;
        ns   = acc ? m_r : m_s;
        nsa  = acc ? 1'b1 : (sd ? 1'b0 : m_sa);
        if (wd) begin
            if (m_dv && !m_taken && !rf && m_drop < c_DROP_MAX) m_drop++;
            nw = 0;
            found = 0;
            for (int b = 0; b < c_NB; b++) begin
                if (!found && b != m_w && !(nrv && b == nd) && !(nsa && b == ns)) begin
                    nw = b;
                    found = 1;
                end
            end
            m_r = m_w;
            m_w = nw;
            m_dv = 1;
            m_taken = 0;
        end else if (take) begin
            m_taken = 1;
        end
        m_d = nd; m_rv = nrv; m_s = ns; m_sa = nsa; m_ack = acc;
    endtask

    // One clock with the given inputs, then compare every output to the model
    task automatic cycle(input bit rs, input bit wd, input bit rf,
                         input bit sq, input bit sd);
        rest = rs; wr_frame_done = wd; rd_frame_start = rf;
        shot_req = sq; shot_done = sd;
        @(posedge clk);
        model_step(rs, wd, rf, sq, sd);
        #1;
        check("w_blk", int'(w_blk), m_w);
        check("disp_blk", int'(r_blk), m_r);
        check("rd_blk", int'(d_blk), m_d);
        check("shot_blk", int'(s_blk), m_s);
        check("disp_valid", int'(dv), int'(m_dv));
        check("shot_active", int'(sa), int'(m_sa));
        check("shot_ack", int'(ack), int'(m_ack));
        check("drop_cnt", int'(drops), m_drop);
        if (m_rv) check("inv_w_ne_d", int'(w_blk == d_blk), 0);
        if (m_sa) check("inv_w_ne_s", int'(w_blk == s_blk), 0);
    endtask

    // Reset, three completed frames, then reader start + frame done:
    // leaves W=2, R=1, D=0 with the reader active.
    task automatic prime_w2_r1_d0();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        cycle(1, 0, 0, 0, 0);
        check("rst_w", int'(w_blk), 0);
        check("rst_valid", int'(dv), 0);
        check("rst_drop", int'(drops), 0);

        // Three frames with no reader: W 0->1->0->1, R 0,1,0, two drops
        cycle(0, 1, 0, 0, 0);
        check("seq1_r", int'(r_blk), 0);
        check("seq1_w", int'(w_blk), 1);
        check("seq1_valid", int'(dv), 1);
        cycle(0, 1, 0, 0, 0);
        check("seq2_w", int'(w_blk), 0);
        cycle(0, 1, 0, 0, 0);
        check("seq3_w", int'(w_blk), 1);
        check("seq3_r", int'(r_blk), 0);
        check("seq3_drop", int'(drops), 2);

        // Reader takes R=0, then frame done: R=1, W=2, no new drop
        cycle(0, 0, 1, 0, 0);
        check("rd_d", int'(d_blk), 0);
        cycle(0, 1, 0, 0, 0);
        check("rd_r", int'(r_blk), 1);
        check("rd_w", int'(w_blk), 2);
        check("rd_drop", int'(drops), 2);

        // Screenshot locks block 1
        cycle(0, 0, 0, 1, 0);
        check("shot_s", int'(s_blk), 1);
        check("shot_ack1", int'(ack), 1);
        cycle(0, 0, 0, 0, 0);
        check("shot_ack0", int'(ack), 0);
        cycle(0, 1, 0, 0, 0);
        check("shot_w3", int'(w_blk), 3);
        cycle(0, 1, 0, 0, 0);
        check("shot_r3", int'(r_blk), 3);
        check("shot_w2", int'(w_blk), 2);
        // Second request while locked is dropped
        cycle(0, 0, 0, 1, 0);
        check("shot_busy_ack", int'(ack), 0);
        check("shot_busy_s", int'(s_blk), 1);
        cycle(0, 0, 0, 0, 1);
        check("shot_rel", int'(sa), 0);
        cycle(0, 1, 0, 0, 0);
        check("rel_r2", int'(r_blk), 2);
        check("rel_w1", int'(w_blk), 1);

        // Simultaneous done + reader start + shot request
        prime_w2_r1_d0();
        cycle(0, 1, 1, 1, 0);
        check("sim_d", int'(d_blk), 1);
        check("sim_s", int'(s_blk), 1);
        check("sim_r", int'(r_blk), 2);
        check("sim_w", int'(w_blk), 0);

        // Mid-sequence reset with all flags set
        cycle(1, 0, 0, 0, 0);
        check("mid_rst_sa", int'(sa), 0);
        check("mid_rst_drop", int'(drops), 0);

        // Shot request with no completed frame
        cycle(0, 0, 0, 1, 0);
        check("nodisp_ack", int'(ack), 0);

        // Randomized event run
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
